// File: rtl/priority_tree_reg.sv
`default_nettype none
// ============================================================================
//  Module      : priority_tree_reg
//  Description : Pipelined one-hot priority reduction tree. Reduces an N-bit
//                request vector pairwise, one register stage per level, down
//                to a lower-half (A) and upper-half (B) result carrying
//                presence, collision/lane error and encoded position.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_tree_reg #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_bits,
    input  logic [N-1:0]     in_err,
    output logic             out_valid,
    output logic             outA,
    output logic             outB,
    output logic             errA,
    output logic             errB,
    output logic [LOG2N-2:0] idxA,
    output logic [LOG2N-2:0] idxB
);

    // Number of registered levels; the last one holds exactly two nodes.
    localparam int c_LVLS = LOG2N - 1;

    for (genvar k = 1; k <= c_LVLS; k++) begin : g_lvl
        // Level k holds N>>k nodes, each with a k-bit position field.
        localparam int c_NODES = N >> k;
        localparam int c_IW    = k;
        localparam int c_PIW   = k - 1;

        logic                    r_vld;
        logic [c_NODES-1:0]      r_y;
        logic [c_NODES-1:0]      r_err;
        logic [c_NODES*c_IW-1:0] r_idx;

        logic                    w_vld;
        logic [c_NODES-1:0]      w_y;
        logic [c_NODES-1:0]      w_err;
        logic [c_NODES*c_IW-1:0] w_idx;

        if (k == 1) begin : g_leaf
            // Combine raw request/error lanes pairwise; leaves carry no position.
            always_comb begin
                w_vld = in_valid;
                w_y   = '0;
                w_err = '0;
                w_idx = '0;
                for (int j = 0; j < c_NODES; j++) begin
                    w_y[j]   = in_bits[2*j] | in_bits[2*j+1];
                    w_err[j] = (in_bits[2*j] & in_bits[2*j+1])
                             | in_err[2*j] | in_err[2*j+1];
                    w_idx[j] = in_bits[2*j+1];
                end
            end
        end else begin : g_node
            // Combine child nodes of the previous level; upper child wins the position.
            always_comb begin
                w_vld = g_lvl[k-1].r_vld;
                w_y   = '0;
                w_err = '0;
                w_idx = '0;
                for (int j = 0; j < c_NODES; j++) begin
                    w_y[j]   = g_lvl[k-1].r_y[2*j] | g_lvl[k-1].r_y[2*j+1];
                    w_err[j] = (g_lvl[k-1].r_y[2*j] & g_lvl[k-1].r_y[2*j+1])
                             | g_lvl[k-1].r_err[2*j] | g_lvl[k-1].r_err[2*j+1];
                    w_idx[j*c_IW +: c_IW] = g_lvl[k-1].r_y[2*j+1]
                        ? {1'b1, g_lvl[k-1].r_idx[(2*j+1)*c_PIW +: c_PIW]}
                        : {1'b0, g_lvl[k-1].r_idx[(2*j)*c_PIW +: c_PIW]};
                end
            end
        end

        // Stage register: valid always advances, data only loads with valid so
        // idle-cycle garbage (including X) never enters the pipe.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld <= 1'b0;
                r_y   <= '0;
                r_err <= '0;
                r_idx <= '0;
            end else begin
                r_vld <= w_vld;
                if (w_vld) begin
                    r_y   <= w_y;
                    r_err <= w_err;
                    r_idx <= w_idx;
                end
            end
        end
    end

    // Final level: node 0 is the lower half, node 1 the upper half.
    assign out_valid = g_lvl[c_LVLS].r_vld;
    assign outA      = g_lvl[c_LVLS].r_y[0];
    assign outB      = g_lvl[c_LVLS].r_y[1];
    assign errA      = g_lvl[c_LVLS].r_err[0];
    assign errB      = g_lvl[c_LVLS].r_err[1];
    assign idxA      = g_lvl[c_LVLS].r_idx[0 +: c_LVLS];
    assign idxB      = g_lvl[c_LVLS].r_idx[c_LVLS +: c_LVLS];

endmodule
`default_nettype wire
